// File: rtl/jtag_tap_ir_if.sv
// Pin-side bundle of the JTAG TAP / instruction register block.
// The slave modport is the TAP itself; the master modport is the pin or chip-side driver.
interface jtag_tap_ir_if #(
  parameter int IR_W = 8
);
  logic            tms;
  logic            tdi;
  logic            dr_so;
  logic            tdo;
  logic            tdo_en;
  logic [IR_W-1:0] ir_out;
  logic            sel_bypass;
  logic            capture_dr;
  logic            shift_dr;
  logic            update_dr;
  logic [3:0]      tap_state;

  modport master (
    output tms, tdi, dr_so,
    input  tdo, tdo_en, ir_out, sel_bypass, capture_dr, shift_dr, update_dr, tap_state
  );

  modport slave (
    input  tms, tdi, dr_so,
    output tdo, tdo_en, ir_out, sel_bypass, capture_dr, shift_dr, update_dr, tap_state
  );
endinterface

// File: rtl/jtag_tap_ir.sv
// IEEE 1149.1 TAP controller with an integrated instruction register.
// Generates IR capture/shift/update internally and decodes the DR-side strobes for the data registers.
module jtag_tap_ir #(
  parameter int              IR_W         = 8,
  parameter logic [IR_W-1:0] RESET_INSTR  = {IR_W{1'b1}},
  parameter bit              CAPTURE_MODE = 1'b0,
  parameter logic [IR_W-1:0] CAPTURE_PAT  = {{(IR_W-2){1'b0}}, 2'b01}
) (
  input  logic          tclk,
  input  logic          treset,
  jtag_tap_ir_if.slave  tap
);

  // Encodings follow the standard 1149.1 state assignment so tap_state can be read directly.
  typedef enum logic [3:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PAU_DR = 4'h3,
    EX2_DR = 4'h0,
    UPD_DR = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PAU_IR = 4'hB,
    EX2_IR = 4'h8,
    UPD_IR = 4'hD
  } tap_state_e;

  tap_state_e      state_q;
  tap_state_e      state_d;
  logic [IR_W-1:0] shift_q;
  logic [IR_W-1:0] ir_q;
  logic [IR_W-1:0] capture_val;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge tclk) begin
    if (treset) begin
      state_q <= TLR;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:    state_d = tap.tms ? TLR    : RTI;
      RTI:    state_d = tap.tms ? SEL_DR : RTI;
      SEL_DR: state_d = tap.tms ? SEL_IR : CAP_DR;
      CAP_DR: state_d = tap.tms ? EX1_DR : SH_DR;
      SH_DR:  state_d = tap.tms ? EX1_DR : SH_DR;
      EX1_DR: state_d = tap.tms ? UPD_DR : PAU_DR;
      PAU_DR: state_d = tap.tms ? EX2_DR : PAU_DR;
      EX2_DR: state_d = tap.tms ? UPD_DR : SH_DR;
      UPD_DR: state_d = tap.tms ? SEL_DR : RTI;
      SEL_IR: state_d = tap.tms ? TLR    : CAP_IR;
      CAP_IR: state_d = tap.tms ? EX1_IR : SH_IR;
      SH_IR:  state_d = tap.tms ? EX1_IR : SH_IR;
      EX1_IR: state_d = tap.tms ? UPD_IR : PAU_IR;
      PAU_IR: state_d = tap.tms ? EX2_IR : PAU_IR;
      EX2_IR: state_d = tap.tms ? UPD_IR : SH_IR;
      UPD_IR: state_d = tap.tms ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  // Mode 1 reflects the upper instruction bits back so the host can read the active opcode.
  assign capture_val = CAPTURE_MODE ? {ir_q[IR_W-1:2], 2'b01} : CAPTURE_PAT;

  // The shift stage only moves in Capture/Shift-IR; the active instruction only in Update-IR or TLR.
  always_ff @(posedge tclk) begin
    if (treset) begin
      shift_q <= '0;
      ir_q    <= RESET_INSTR;
    end else begin
      unique case (state_q)
        TLR:     ir_q    <= RESET_INSTR;
        CAP_IR:  shift_q <= capture_val;
        SH_IR:   shift_q <= {tap.tdi, shift_q[IR_W-1:1]};
        UPD_IR:  ir_q    <= shift_q;
        default: ;
      endcase
    end
  end

  // All outputs decode registered state only, so none can glitch with TMS.
  always_comb begin
    tap.tdo = 1'b0;
    if (state_q == SH_IR) begin
      tap.tdo = shift_q[0];
    end else if (state_q == SH_DR) begin
      tap.tdo = tap.dr_so;
    end
  end

  assign tap.tdo_en     = (state_q == SH_IR) || (state_q == SH_DR);
  assign tap.ir_out     = ir_q;
  assign tap.sel_bypass = (ir_q == {IR_W{1'b1}});
  assign tap.capture_dr = (state_q == CAP_DR);
  assign tap.shift_dr   = (state_q == SH_DR);
  assign tap.update_dr  = (state_q == UPD_DR);
  assign tap.tap_state  = state_q;

endmodule

// File: tb/tb_jtag_tap_ir.sv
// Directed bench for jtag_tap_ir: a vector table for the main walk plus hand sequences for
// capture modes, five-TMS reset, pause/resume and reset during shift.
module tb_jtag_tap_ir;

  logic tclk;
  logic treset;
  logic tms;
  logic tdi;
  logic dr_so;

  int n_cmp = 0;
  int n_bad = 0;

  jtag_tap_ir_if #(.IR_W(8)) if0 ();
  jtag_tap_ir_if #(.IR_W(8)) if1 ();

  assign if0.tms   = tms;
  assign if0.tdi   = tdi;
  assign if0.dr_so = dr_so;
  assign if1.tms   = tms;
  assign if1.tdi   = tdi;
  assign if1.dr_so = dr_so;

  jtag_tap_ir #(.IR_W(8), .CAPTURE_MODE(1'b0)) dut0 (.tclk(tclk), .treset(treset), .tap(if0));
  jtag_tap_ir #(.IR_W(8), .CAPTURE_MODE(1'b1)) dut1 (.tclk(tclk), .treset(treset), .tap(if1));

  initial tclk = 1'b0;
  always #5 tclk = ~tclk;

  typedef struct {
    logic       rst;
    logic       tms;
    logic       tdi;
    logic       dr_so;
    logic [3:0] st;
    logic [7:0] ir;
    logic       tdo;
    logic       en;
    logic       byp;
    logic [2:0] strb;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic m, input logic d, input logic s,
                     input logic [3:0] st, input logic [7:0] ir, input logic o,
                     input logic en, input logic byp, input logic [2:0] strb);
    vec_t v;
    v.rst = r; v.tms = m; v.tdi = d; v.dr_so = s;
    v.st = st; v.ir = ir; v.tdo = o; v.en = en; v.byp = byp; v.strb = strb;
    vecs.push_back(v);
  endtask

  task automatic step(input logic m, input logic d);
    treset = 1'b0;
    tms    = m;
    tdi    = d;
    @(posedge tclk);
    #1;
  endtask

  task automatic enter_shift_ir();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("enter_shir_state", 32'(if0.tap_state), 32'hA);
  endtask

  // From RTI: full IR scan of din, recording TDO of both capture modes, ending back in RTI.
  task automatic shift_ir_full(input logic [7:0] din, input logic [7:0] exp_cap1);
    logic [7:0] cap0;
    logic [7:0] cap1;
    enter_shift_ir();
    for (int i = 0; i < 8; i++) begin
      cap0[i] = if0.tdo;
      cap1[i] = if1.tdo;
      step(i == 7, din[i]);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("scan_cap_mode0", 32'(cap0), 32'h01);
    check("scan_cap_mode1", 32'(cap1), 32'(exp_cap1));
    check("scan_ir_mode0", 32'(if0.ir_out), 32'(din));
    check("scan_ir_mode1", 32'(if1.ir_out), 32'(din));
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] dat;

    treset = 1'b1;
    tms    = 1'b0;
    tdi    = 1'b0;
    dr_so  = 1'b0;

    // Reset, walk to Shift-IR, scan 0x3C, update; then a Shift-DR pass with pause.
    pat = 8'h3C;
    add(1, 0, 0, 0, 4'hF, 8'hFF, 0, 0, 1, 3'b000);
    add(0, 0, 0, 0, 4'hC, 8'hFF, 0, 0, 1, 3'b000);
    add(0, 1, 0, 0, 4'h7, 8'hFF, 0, 0, 1, 3'b000);
    add(0, 1, 0, 0, 4'h4, 8'hFF, 0, 0, 1, 3'b000);
    add(0, 0, 0, 0, 4'hE, 8'hFF, 0, 0, 1, 3'b000);
    add(0, 0, 0, 0, 4'hA, 8'hFF, 1, 1, 1, 3'b000);
    for (int i = 0; i < 7; i++) add(0, 0, pat[i], 0, 4'hA, 8'hFF, 0, 1, 1, 3'b000);
    add(0, 1, pat[7], 0, 4'h9, 8'hFF, 0, 0, 1, 3'b000);
    add(0, 1, 0, 0, 4'hD, 8'hFF, 0, 0, 1, 3'b000);
    add(0, 0, 0, 0, 4'hC, 8'h3C, 0, 0, 0, 3'b000);
    add(0, 1, 0, 0, 4'h7, 8'h3C, 0, 0, 0, 3'b000);
    add(0, 0, 0, 0, 4'h6, 8'h3C, 0, 0, 0, 3'b100);
    add(0, 0, 0, 1, 4'h2, 8'h3C, 1, 1, 0, 3'b010);
    add(0, 0, 0, 0, 4'h2, 8'h3C, 0, 1, 0, 3'b010);
    add(0, 0, 0, 1, 4'h2, 8'h3C, 1, 1, 0, 3'b010);
    add(0, 1, 0, 1, 4'h1, 8'h3C, 0, 0, 0, 3'b000);
    add(0, 0, 0, 0, 4'h3, 8'h3C, 0, 0, 0, 3'b000);
    add(0, 1, 0, 0, 4'h0, 8'h3C, 0, 0, 0, 3'b000);
    add(0, 1, 0, 0, 4'h5, 8'h3C, 0, 0, 0, 3'b001);
    add(0, 0, 0, 0, 4'hC, 8'h3C, 0, 0, 0, 3'b000);

    foreach (vecs[k]) begin
      treset = vecs[k].rst;
      tms    = vecs[k].tms;
      tdi    = vecs[k].tdi;
      dr_so  = vecs[k].dr_so;
      @(posedge tclk);
      #1;
      check($sformatf("v%0d_state", k), 32'(if0.tap_state), 32'(vecs[k].st));
      check($sformatf("v%0d_ir", k), 32'(if0.ir_out), 32'(vecs[k].ir));
      check($sformatf("v%0d_tdo", k), 32'(if0.tdo), 32'(vecs[k].tdo));
      check($sformatf("v%0d_tdo_en", k), 32'(if0.tdo_en), 32'(vecs[k].en));
      check($sformatf("v%0d_bypass", k), 32'(if0.sel_bypass), 32'(vecs[k].byp));
      check($sformatf("v%0d_strobes", k),
            32'({if0.capture_dr, if0.shift_dr, if0.update_dr}), 32'(vecs[k].strb));
    end
    dr_so = 1'b0;

    // Capture mode 1 with IR=0x3C reflects 0x3D; mode 0 always 0x01.
    shift_ir_full(8'h5A, 8'h3D);

    // Five TMS=1 from mid Shift-IR reach TLR; the next TLR edge restores BYPASS.
    enter_shift_ir();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("tms5_state", 32'(if0.tap_state), 32'hF);
    check("tms5_state_m1", 32'(if1.tap_state), 32'hF);
    step(1'b1, 1'b0);
    check("tms5_ir", 32'(if0.ir_out), 32'hFF);
    check("tms5_bypass", 32'(if0.sel_bypass), 32'h1);
    step(1'b0, 1'b0);

    // Scan split by a long Pause-IR; the update shows the shift stage held its contents.
    dat = 8'h3C;
    enter_shift_ir();
    for (int i = 0; i < 4; i++) step(1'b0, dat[i]);
    step(1'b1, dat[4]);
    check("pause_ex1", 32'(if0.tap_state), 32'h9);
    step(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("pause%0d_state", i), 32'(if0.tap_state), 32'hB);
      check($sformatf("pause%0d_tdo_en", i), 32'(if0.tdo_en), 32'h0);
      step(1'b0, ~dat[i % 8]);
    end
    step(1'b1, 1'b1);
    check("pause_ex2", 32'(if0.tap_state), 32'h8);
    step(1'b0, 1'b1);
    check("pause_resume", 32'(if0.tap_state), 32'hA);
    check("pause_resume_en", 32'(if0.tdo_en), 32'h1);
    step(1'b0, dat[5]);
    step(1'b0, dat[6]);
    step(1'b1, dat[7]);
    step(1'b1, 1'b0);
    check("pause_ir_hold", 32'(if0.ir_out), 32'hFF);
    step(1'b0, 1'b0);
    check("pause_ir", 32'(if0.ir_out), 32'h3C);
    check("pause_ir_m1", 32'(if1.ir_out), 32'h3C);

    // Reset mid-shift overrides TMS and clears the shift stage.
    enter_shift_ir();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    treset = 1'b1;
    tms    = 1'b0;
    tdi    = 1'b1;
    @(posedge tclk);
    #1;
    check("rst_state", 32'(if0.tap_state), 32'hF);
    check("rst_ir", 32'(if0.ir_out), 32'hFF);
    check("rst_tdo_en", 32'(if0.tdo_en), 32'h0);
    check("rst_shift", 32'(dut0.shift_q), 32'h0);
    check("rst_shift_m1", 32'(dut1.shift_q), 32'h0);
    treset = 1'b0;
    step(1'b0, 1'b0);
    check("rst_rti", 32'(if0.tap_state), 32'hC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
